// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the two requesters, the shared port and the arbiter.
interface mem_port_arbiter_if;
   logic req0;
   logic req1;
   logic done;
   logic gnt0;
   logic gnt1;
   logic sel;
   logic busy;
   logic timeout_err;

   // Arbiter side: consumes requests and completion, produces grants and select.
   modport slave (
      input  req0,
      input  req1,
      input  done,
      output gnt0,
      output gnt1,
      output sel,
      output busy,
      output timeout_err
   );

   // Requester/port side: the mirror image of the arbiter.
   modport master (
      output req0,
      output req1,
      output done,
      input  gnt0,
      input  gnt1,
      input  sel,
      input  busy,
      input  timeout_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a shared memory port. Requester 0 is
// instruction fetch, requester 1 is load/store. Ownership is held until done,
// abandon or watchdog expiry; all outputs come straight from flops.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.slave  bus
);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN0 = 2'd1;
   localparam logic [1:0] OWN1 = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          gnt0_q,  gnt0_d;
   logic          gnt1_q,  gnt1_d;
   logic          sel_q,   sel_d;
   logic          busy_q,  busy_d;
   logic          terr_q,  terr_d;
   logic          prio_q,  prio_d;
   logic [CW-1:0] cnt_q,   cnt_d;

   logic          own_req;

   // Request of whichever requester currently owns the port.
   always_comb begin
      own_req = 1'b0;
      if (state_q == OWN0) begin
         own_req = bus.req0;
      end else if (state_q == OWN1) begin
         own_req = bus.req1;
      end
   end

   // Next-state: grant in IDLE by priority, release on done/abandon/watchdog.
   always_comb begin
      state_d = state_q;
      gnt0_d  = gnt0_q;
      gnt1_d  = gnt1_q;
      sel_d   = sel_q;
      prio_d  = prio_q;
      cnt_d   = cnt_q;
      terr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req0 && (!bus.req1 || !prio_q)) begin
               state_d = OWN0;
               gnt0_d  = 1'b1;
               sel_d   = 1'b0;
               cnt_d   = '0;
               prio_d  = 1'b1;
            end else if (bus.req1) begin
               state_d = OWN1;
               gnt1_d  = 1'b1;
               sel_d   = 1'b1;
               cnt_d   = '0;
               prio_d  = 1'b0;
            end
         end
         OWN0, OWN1: begin
            // done takes precedence over the watchdog in the same cycle
            if (bus.done || !own_req) begin
               state_d = IDLE;
               gnt0_d  = 1'b0;
               gnt1_d  = 1'b0;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = IDLE;
               gnt0_d  = 1'b0;
               gnt1_d  = 1'b0;
               terr_d  = 1'b1;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
         end
      endcase
      busy_d = gnt0_d | gnt1_d;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         sel_q   <= 1'b0;
         busy_q  <= 1'b0;
         terr_q  <= 1'b0;
         prio_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
         terr_q  <= terr_d;
         prio_q  <= prio_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.gnt0        = gnt0_q;
   assign bus.gnt1        = gnt1_q;
   assign bus.sel         = sel_q;
   assign bus.busy        = busy_q;
   assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT=16.
module tb_mem_port_arbiter;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Both grants at once must never be seen.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         assert (!(bus.gnt0 && bus.gnt1)) else begin
            errors++;
            $display("FAIL mutex: gnt0=%b gnt1=%b required not both 1", bus.gnt0, bus.gnt1);
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; bus.req0 = 1'b1; bus.req1 = 1'b1; bus.done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({bus.gnt0, bus.gnt1, bus.sel, bus.busy, bus.timeout_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000",
                     {bus.gnt0, bus.gnt1, bus.sel, bus.busy, bus.timeout_err});
         end
      end
      rst = 1'b0;
      step();
      checks++;
      if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.sel !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL first_grant: gnt0=%b gnt1=%b sel=%b busy=%b required 1 0 0 1",
                  bus.gnt0, bus.gnt1, bus.sel, bus.busy);
      end
   endtask

   // Starts just after the grant to requester 0; both requests held.
   task automatic test_round_robin();
      logic exp;
      for (int i = 0; i < 4; i++) begin
         exp = (i % 2) == 1;
         checks++;
         if (bus.gnt0 !== !exp || bus.gnt1 !== exp || bus.sel !== exp) begin
            errors++;
            $display("FAIL rr_grant%0d: gnt0=%b gnt1=%b sel=%b required %b %b %b",
                     i, bus.gnt0, bus.gnt1, bus.sel, !exp, exp, exp);
         end
         step();
         step();
         bus.done = 1'b1;
         step();
         bus.done = 1'b0;
         checks++;
         if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.busy !== 1'b0 || bus.sel !== exp) begin
            errors++;
            $display("FAIL rr_gap%0d: gnt0=%b gnt1=%b busy=%b sel=%b required 0 0 0 %b",
                     i, bus.gnt0, bus.gnt1, bus.busy, bus.sel, exp);
         end
         step();
      end
      checks++;
      if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
         errors++;
         $display("FAIL rr_wrap: gnt0=%b gnt1=%b required 1 0", bus.gnt0, bus.gnt1);
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      step();
      checks++;
      if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL rr_abandon: busy=%b terr=%b required 0 0", bus.busy, bus.timeout_err);
      end
   endtask

   task automatic test_timeout();
      int high;
      bus.req1 = 1'b1;
      step();
      high = 0;
      for (int k = 0; k < 16; k++) begin
         if (bus.gnt1 === 1'b1 && bus.timeout_err === 1'b0) high++;
         step();
      end
      checks++;
      if (high !== 16) begin
         errors++;
         $display("FAIL to_hold: gnt1 high cycles=%0d required 16", high);
      end
      checks++;
      if (bus.gnt1 !== 1'b0 || bus.timeout_err !== 1'b1 || bus.sel !== 1'b1) begin
         errors++;
         $display("FAIL to_pulse: gnt1=%b terr=%b sel=%b required 0 1 1",
                  bus.gnt1, bus.timeout_err, bus.sel);
      end
      bus.req1 = 1'b0;
      step();
      checks++;
      if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL to_single: terr=%b busy=%b required 0 0", bus.timeout_err, bus.busy);
      end
   endtask

   task automatic test_done_at_limit();
      bus.req1 = 1'b1;
      step();
      for (int k = 0; k < 15; k++) step();
      checks++;
      if (bus.gnt1 !== 1'b1) begin
         errors++;
         $display("FAIL lim_held: gnt1=%b required 1", bus.gnt1);
      end
      bus.done = 1'b1;
      step();
      bus.done = 1'b0; bus.req1 = 1'b0;
      checks++;
      if (bus.gnt1 !== 1'b0 || bus.timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL lim_release: gnt1=%b terr=%b required 0 0", bus.gnt1, bus.timeout_err);
      end
      // done while idle must not start anything
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      checks++;
      if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_done: terr=%b busy=%b required 0 0", bus.timeout_err, bus.busy);
      end
   endtask

   task automatic test_abandon();
      bus.req0 = 1'b1;
      step();
      checks++;
      if (bus.gnt0 !== 1'b1 || bus.sel !== 1'b0) begin
         errors++;
         $display("FAIL ab_grant: gnt0=%b sel=%b required 1 0", bus.gnt0, bus.sel);
      end
      step();
      bus.req0 = 1'b0;
      step();
      checks++;
      if (bus.gnt0 !== 1'b0 || bus.timeout_err !== 1'b0 || bus.sel !== 1'b0) begin
         errors++;
         $display("FAIL ab_release: gnt0=%b terr=%b sel=%b required 0 0 0",
                  bus.gnt0, bus.timeout_err, bus.sel);
      end
      step();
   endtask

   task automatic test_reset_mid();
      bus.req1 = 1'b1;
      step();
      checks++;
      if (bus.gnt1 !== 1'b1 || bus.sel !== 1'b1) begin
         errors++;
         $display("FAIL rm_grant: gnt1=%b sel=%b required 1 1", bus.gnt1, bus.sel);
      end
      rst = 1'b1; bus.req0 = 1'b1;
      step();
      checks++;
      if (bus.gnt1 !== 1'b0 || bus.sel !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL rm_clear: gnt1=%b sel=%b busy=%b required 0 0 0",
                  bus.gnt1, bus.sel, bus.busy);
      end
      rst = 1'b0;
      step();
      checks++;
      if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.sel !== 1'b0) begin
         errors++;
         $display("FAIL rm_prio: gnt0=%b gnt1=%b sel=%b required 1 0 0",
                  bus.gnt0, bus.gnt1, bus.sel);
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      step();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_round_robin();
      test_timeout();
      test_done_at_limit();
      test_abandon();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "time limit");
   end
endmodule
